// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg                                         |
// | Shared encodings for the MIPS hazard scheduler.                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit positions of the decoder's ControlLines bundle.
  localparam int CL_REGWRITE = 11;
  localparam int CL_MEMREAD  = 3;
  localparam int CL_BRANCH   = 2;

  typedef struct packed {
    logic       vld;
    logic       ld;
    logic [4:0] dst;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if                                          |
// | Decode-stage hazard bus: ID instruction fields in, controls out. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             inst_valid;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             uses_rs;
  logic             uses_rt;
  logic             reg_write;
  logic             mem_read;
  logic [4:0]       dest_reg;
  logic             branch_taken;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             bubble_idex;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output inst_valid, rs, rt, uses_rs, uses_rt, reg_write, mem_read, dest_reg, branch_taken,
    input  stall_pc, stall_ifid, flush_ifid, bubble_idex, state, stall_count, flush_count
  );

  modport slave (
    input  inst_valid, rs, rt, uses_rs, uses_rt, reg_write, mem_read, dest_reg, branch_taken,
    output stall_pc, stall_ifid, flush_ifid, bubble_idex, state, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl_scoreboard                                  |
// | Shift-register record of in-flight writers, two pending ports.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipeline_hazard_ctrl_scoreboard
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire sb_entry_t  push,
  input  wire logic [4:0] rd_a,
  input  wire logic [4:0] rd_b,
  output logic            pend_a,
  output logic            pend_b
);

  sb_entry_t [DEPTH-1:0] sb_q;
  sb_entry_t [DEPTH-1:0] sb_d;

  function automatic logic match(input sb_entry_t e, input logic [4:0] r);
    return e.vld && (e.dst == r) && (r != REG_ZERO);
  endfunction

  always_comb begin
    sb_d = sb_q;
    for (int k = DEPTH - 1; k > 0; k--) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[0] = push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k].vld <= 1'b0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  // With forwarding only a load still in EX cannot be bypassed in time.
  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    if (FWD_EN) begin
      pend_a = match(sb_q[0], rd_a) && sb_q[0].ld;
      pend_b = match(sb_q[0], rd_b) && sb_q[0].ld;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        pend_a = pend_a | match(sb_q[k], rd_a);
        pend_b = pend_b | match(sb_q[k], rd_b);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                             |
// | RAW stall / branch flush scheduler with saturating perf counters.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input wire logic                clk,
  input wire logic                rst,
  pipeline_hazard_ctrl_if.slave   bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic      w_pend_a, w_pend_b;
  logic      w_in_flush;
  logic      w_hazard;
  logic      w_flush;
  sb_entry_t w_push;

  assign w_in_flush = (state_q == ST_FLUSH);
  assign w_hazard   = bus.inst_valid && !w_in_flush &&
                      ((bus.uses_rs && w_pend_a) || (bus.uses_rt && w_pend_b));
  assign w_flush    = bus.branch_taken && bus.inst_valid && !w_hazard && !w_in_flush;

  assign w_push.vld = bus.inst_valid && bus.reg_write && !w_hazard && !w_in_flush &&
                      (bus.dest_reg != REG_ZERO);
  assign w_push.ld  = bus.mem_read;
  assign w_push.dst = bus.dest_reg;

  pipeline_hazard_ctrl_scoreboard #(
    .DEPTH  (DEPTH),
    .FWD_EN (FWD_EN)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .rd_a   (bus.rs),
    .rd_b   (bus.rt),
    .pend_a (w_pend_a),
    .pend_b (w_pend_b)
  );

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (w_hazard)     state_d = ST_STALL;
        else if (w_flush) state_d = ST_FLUSH;
        else              state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (w_hazard && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + 1'b1;
    if (w_flush && (flush_count_q != {CNT_W{1'b1}})) flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.stall_pc    = w_hazard && !rst;
  assign bus.stall_ifid  = w_hazard && !rst;
  assign bus.bubble_idex = w_hazard && !rst;
  assign bus.flush_ifid  = w_flush && !rst;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_count_q;
  assign bus.flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl                                          |
// | Directed bench over three configurations of the hazard scheduler.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // if0: no forwarding, if1: forwarding, if2: no forwarding with 2-bit counters
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  if2 ();

  pipeline_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  pipeline_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  pipeline_hazard_ctrl #(.DEPTH(3), .FWD_EN(1'b0), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic mr,
                       input logic [4:0] dst, input logic bt);
    if0.inst_valid = v;  if1.inst_valid = v;  if2.inst_valid = v;
    if0.rs = rs;         if1.rs = rs;         if2.rs = rs;
    if0.rt = rt;         if1.rt = rt;         if2.rt = rt;
    if0.uses_rs = urs;   if1.uses_rs = urs;   if2.uses_rs = urs;
    if0.uses_rt = urt;   if1.uses_rt = urt;   if2.uses_rt = urt;
    if0.reg_write = rw;  if1.reg_write = rw;  if2.reg_write = rw;
    if0.mem_read = mr;   if1.mem_read = mr;   if2.mem_read = mr;
    if0.dest_reg = dst;  if1.dest_reg = dst;  if2.dest_reg = dst;
    if0.branch_taken = bt; if1.branch_taken = bt; if2.branch_taken = bt;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if0.state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", if0.state); end
    total++; if (if0.stall_count !== 16'd0 || if0.flush_count !== 16'd0) begin bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", if0.stall_count, if0.flush_count); end
    total++; if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex} !== 4'b0) begin bad++; $display("FAIL reset_outs: got %b want 0000", {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex}); end
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    total++; if (if0.stall_pc !== 1'b0) begin bad++; $display("FAIL raw_producer: got %b want 0", if0.stall_pc); end
    tick();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if ({if0.stall_pc, if0.stall_ifid, if0.bubble_idex} !== 3'b111) begin bad++; $display("FAIL raw_stall cyc%0d: got %b want 111", i, {if0.stall_pc, if0.stall_ifid, if0.bubble_idex}); end
      tick();
      total++; if (if0.state !== 2'd1) begin bad++; $display("FAIL raw_state cyc%0d: got %0d want 1", i, if0.state); end
    end
    #2;
    total++; if (if0.stall_pc !== 1'b0) begin bad++; $display("FAIL raw_release: got %b want 0", if0.stall_pc); end
    total++; if (if0.stall_count !== 16'd3) begin bad++; $display("FAIL raw_count: got %0d want 3", if0.stall_count); end
    tick();
    idle();
    total++; if (if0.state !== 2'd0) begin bad++; $display("FAIL raw_run: got %0d want 0", if0.state); end
  endtask

  task automatic test_load_use_fwd();
    do_reset();
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 1'b0);
    total++; if (if1.stall_pc !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", if1.stall_pc); end
    tick();
    #2;
    total++; if (if1.stall_pc !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", if1.stall_pc); end
    total++; if (if1.stall_count !== 16'd1) begin bad++; $display("FAIL lu_count: got %0d want 1", if1.stall_count); end
    tick();
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 1'b0);
    total++; if (if1.stall_pc !== 1'b0) begin bad++; $display("FAIL alu_fwd_stall: got %b want 0", if1.stall_pc); end
    tick();
    idle();
    total++; if (if1.stall_count !== 16'd1) begin bad++; $display("FAIL alu_fwd_count: got %0d want 1", if1.stall_count); end
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (if0.stall_pc !== 1'b0) begin bad++; $display("FAIL zero_nofwd: got %b want 0", if0.stall_pc); end
    total++; if (if1.stall_pc !== 1'b0) begin bad++; $display("FAIL zero_fwd: got %b want 0", if1.stall_pc); end
    tick();
    idle();
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    total++; if (if0.flush_ifid !== 1'b1 || if0.stall_pc !== 1'b0) begin bad++; $display("FAIL br_flush: got flush=%b stall=%b want 1/0", if0.flush_ifid, if0.stall_pc); end
    tick();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 1'b1);
    total++; if (if0.state !== 2'd2) begin bad++; $display("FAIL br_state: got %0d want 2", if0.state); end
    total++; if (if0.flush_count !== 16'd1) begin bad++; $display("FAIL br_count: got %0d want 1", if0.flush_count); end
    total++; if (if0.flush_ifid !== 1'b0 || if0.stall_pc !== 1'b0) begin bad++; $display("FAIL br_squash: got flush=%b stall=%b want 0/0", if0.flush_ifid, if0.stall_pc); end
    tick();
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    total++; if (if0.state !== 2'd0 || if0.flush_count !== 16'd1) begin bad++; $display("FAIL br_after: got state=%0d cnt=%0d want 0/1", if0.state, if0.flush_count); end
    total++; if (if0.stall_pc !== 1'b0) begin bad++; $display("FAIL br_no_entry: got %b want 0", if0.stall_pc); end
    tick();
    idle();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++; if (if0.stall_pc !== 1'b1 || if0.flush_ifid !== 1'b0) begin bad++; $display("FAIL brh_stall cyc%0d: got stall=%b flush=%b want 1/0", i, if0.stall_pc, if0.flush_ifid); end
      tick();
    end
    #2;
    total++; if (if0.state !== 2'd1 || if0.flush_ifid !== 1'b1 || if0.stall_pc !== 1'b0) begin bad++; $display("FAIL brh_release: got state=%0d flush=%b stall=%b want 1/1/0", if0.state, if0.flush_ifid, if0.stall_pc); end
    tick();
    idle();
    total++; if (if0.state !== 2'd2) begin bad++; $display("FAIL brh_flush_state: got %0d want 2", if0.state); end
    tick();
    total++; if (if0.state !== 2'd0 || if0.flush_count !== 16'd1) begin bad++; $display("FAIL brh_run: got state=%0d cnt=%0d want 0/1", if0.state, if0.flush_count); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0);
    tick();
    total++; if (if0.state !== 2'd1) begin bad++; $display("FAIL rms_in_stall: got %0d want 1", if0.state); end
    rst = 1'b1;
    #2;
    total++; if ({if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex} !== 4'b0) begin bad++; $display("FAIL rms_forced: got %b want 0000", {if0.stall_pc, if0.stall_ifid, if0.flush_ifid, if0.bubble_idex}); end
    tick();
    rst = 1'b0;
    #2;
    total++; if (if0.state !== 2'd0 || if0.stall_count !== 16'd0) begin bad++; $display("FAIL rms_cleared: got state=%0d cnt=%0d want 0/0", if0.state, if0.stall_count); end
    total++; if (if0.stall_pc !== 1'b0) begin bad++; $display("FAIL rms_empty_pipe: got %b want 0", if0.stall_pc); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0);
    repeat (4) tick();
    drive(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
    #2;
    total++; if (if2.stall_pc !== 1'b0) begin bad++; $display("FAIL sat_release: got %b want 0", if2.stall_pc); end
    total++; if (if2.stall_count !== 2'd3) begin bad++; $display("FAIL sat_hold: got %0d want 3", if2.stall_count); end
    total++; if (if0.stall_count !== 16'd6) begin bad++; $display("FAIL sat_wide: got %0d want 6", if0.stall_count); end
    tick();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_nofwd();
    test_load_use_fwd();
    test_reg_zero();
    test_branch_flush();
    test_branch_hazard();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
